truth_table_checker: RTL

- Hardware response-side companion for 4-input combinational sample modules, i.e. any `sample*` DUT with output F and inputs A, B, C, D.
- It sweeps all 16 input vectors into the DUT in order, waits a programmable settle time, and samples F for each vector.
- It builds the observed truth table and compares it against a parameterised expected table.
- It reports the mismatch count, the first failing vector and pass/done status, so synthesised or simulated sample logic can be checked without a hand-written `$monitor` bench.

---
 rtl/truth_table_checker_if.sv | 27 ++
 rtl/truth_table_checker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and the combinational sample under test,
// plus the sweep control and result signals.
interface truth_table_checker_if;
  logic        start;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        F;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] observed;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;
  logic        fail_valid;

  modport slave (
    input  start, F,
    output A, B, C, D, busy, done, pass, observed, mismatch_cnt, first_fail, fail_valid
  );

  modport master (
    output start, F,
    input  A, B, C, D, busy, done, pass, observed, mismatch_cnt, first_fail, fail_valid
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps all 16 vectors into a 4-input sample, samples F after a settle time
// and compares the captured truth table against EXPECTED.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED = 16'h6996,
  parameter int          SETTLE   = 1
) (
  input logic clk,
  input logic rst,
  truth_table_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] observed_q, observed_d;
  logic [4:0]  mismatch_q, mismatch_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic        fail_valid_q, fail_valid_d;
  logic        miss;
  logic [4:0]  mismatch_inc;

  assign miss         = bus.F != EXPECTED[index_q];
  assign mismatch_inc = mismatch_q + {4'd0, miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      index_q      <= 4'd0;
      cnt_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      observed_q   <= 16'd0;
      mismatch_q   <= 5'd0;
      first_fail_q <= 4'd0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      observed_q   <= observed_d;
      mismatch_q   <= mismatch_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    observed_d   = observed_q;
    mismatch_d   = mismatch_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          index_d      = 4'd0;
          cnt_d        = RELOAD;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          observed_d   = 16'd0;
          mismatch_d   = 5'd0;
          first_fail_d = 4'd0;
          fail_valid_d = 1'b0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        observed_d[index_q] = bus.F;
        mismatch_d          = mismatch_inc;
        if (miss && !fail_valid_q) begin
          first_fail_d = index_q;
          fail_valid_d = 1'b1;
        end
        // The last vector's compare result must already count toward pass.
        if (index_q == 4'd15) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mismatch_inc == 5'd0);
          state_d = S_DONE;
        end else begin
          index_d = index_q + 4'd1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.A            = index_q[3];
  assign bus.B            = index_q[2];
  assign bus.C            = index_q[1];
  assign bus.D            = index_q[0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.observed     = observed_q;
  assign bus.mismatch_cnt = mismatch_q;
  assign bus.first_fail   = first_fail_q;
  assign bus.fail_valid   = fail_valid_q;

endmodule
